// File: rtl/matrix_repack.sv
// -----------------------------------------------------------------------------
// matrix_repack
//
// Converts a matrix between two layouts, one element per clock:
//   pack   (mode=0): padded MAX_ROWS x MAX_COLS layout -> dense row-major r x c
//   unpack (mode=1): dense row-major r x c -> padded MAX_ROWS x MAX_COLS layout
// Slots that hold no valid element are zero in the result.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start     operation request, sampled only while idle
//   mode      0 = pack, 1 = unpack (latched at start)
//   r, c      valid row / column count (latched at start)
//   data_in   N = MAX_ROWS*MAX_COLS elements, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//             (snapshotted at start)
//   data_out  result, same packing, held until the next successful commit
//   busy      high from the cycle after an accepted start until done
//   done      one-cycle completion pulse
//   dim_err   set with done when r/c are illegal, cleared by the next accepted start
//
// Optional build macro MATRIX_REPACK_EARLY_EXIT_EN: when defined, the scan
// stops at the last valid padded position (r-1, c-1) instead of walking all N
// positions. The result is identical; only the latency shrinks.
// -----------------------------------------------------------------------------
module matrix_repack #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_ROWS   = 5,
  parameter int MAX_COLS   = 5,
  parameter int DIM_W      = 3
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  input  logic                                        mode,
  input  logic [DIM_W-1:0]                            r,
  input  logic [DIM_W-1:0]                            c,
  input  logic [MAX_ROWS*MAX_COLS*DATA_WIDTH-1:0]     data_in,
  output logic [MAX_ROWS*MAX_COLS*DATA_WIDTH-1:0]     data_out,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        dim_err
);

  localparam int N     = MAX_ROWS * MAX_COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    ERR    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_PACK   = 1'b0,
    MODE_UNPACK = 1'b1
  } mode_e;

  state_e                state;
  mode_e                 mode_q;
  logic [DIM_W-1:0]      r_q;
  logic [DIM_W-1:0]      c_q;
  logic [DIM_W-1:0]      row;
  logic [DIM_W-1:0]      col;
  logic [IDX_W-1:0]      pos;
  logic [IDX_W-1:0]      dense_idx;
  logic [DATA_WIDTH-1:0] in_buf   [N];
  logic [DATA_WIDTH-1:0] work_buf [N];

  logic dims_bad;
  logic elem_valid;
  logic last_valid;
  logic scan_last;

  // Dimension legality is judged on the live inputs, since it is only used on
  // the accepting edge in IDLE.
  assign dims_bad = (r == '0) || (c == '0) ||
                    (r > DIM_W'(MAX_ROWS)) || (c > DIM_W'(MAX_COLS));

  // row/col track pos incrementally, so no divide/modulo is needed.
  assign elem_valid = (row < r_q) && (col < c_q);

  // The padded position (r-1, c-1) carries the final valid element. dense_idx
  // is not advanced past it, so it stays within 0..r*c-1.
  assign last_valid = (row == r_q - DIM_W'(1)) && (col == c_q - DIM_W'(1));

`ifdef MATRIX_REPACK_EARLY_EXIT_EN
  assign scan_last = last_valid;
`else
  assign scan_last = (pos == IDX_W'(N - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_q    <= MODE_PACK;
      r_q       <= '0;
      c_q       <= '0;
      row       <= '0;
      col       <= '0;
      pos       <= '0;
      dense_idx <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dim_err   <= 1'b0;
      // NOTE: the buffers are register arrays rather than RAM, and a reset
      // must discard any partial result, so every entry is cleared here.
      for (int k = 0; k < N; k++) begin
        in_buf[k]   <= '0;
        work_buf[k] <= '0;
      end
    end else begin
      // done is a pulse: only COMMIT and ERR raise it for a single cycle.
      done <= 1'b0;

      case (state)
        IDLE: begin
          // busy stays up through the done cycle and drops here, unless a
          // new operation is accepted on this same edge.
          busy <= 1'b0;
          if (start) begin
            mode_q  <= mode_e'(mode);
            r_q     <= r;
            c_q     <= c;
            dim_err <= 1'b0;
            for (int k = 0; k < N; k++) begin
              in_buf[k] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            if (dims_bad) begin
              state <= ERR;
            end else begin
              for (int k = 0; k < N; k++) begin
                work_buf[k] <= '0;
              end
              pos       <= '0;
              row       <= '0;
              col       <= '0;
              dense_idx <= '0;
              busy      <= 1'b1;
              state     <= SCAN;
            end
          end
        end

        SCAN: begin
          if (elem_valid) begin
            if (mode_q == MODE_UNPACK) begin
              work_buf[pos] <= in_buf[dense_idx];
            end else begin
              work_buf[dense_idx] <= in_buf[pos];
            end
            if (!last_valid) begin
              dense_idx <= dense_idx + IDX_W'(1);
            end
          end

          if (col == DIM_W'(MAX_COLS - 1)) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
          pos <= pos + IDX_W'(1);

          if (scan_last) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          for (int k = 0; k < N; k++) begin
            data_out[k*DATA_WIDTH +: DATA_WIDTH] <= work_buf[k];
          end
          done  <= 1'b1;
          state <= IDLE;
        end

        ERR: begin
          // Illegal dimensions: report and leave data_out untouched.
          done    <= 1'b1;
          dim_err <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
